// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, Rcon, byte/word/state types and the
// GF(2^8) helpers used by the inverse cipher datapath.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, KEXP, DEC} fsm_t;

  function automatic byte_t rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte n of the state sits at [127-8n -: 8], n = 4*column + row.
  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic word_t inv_mix_column(input word_t w);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
            gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
            gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
            gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational ROM; one instance per state byte.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  localparam logic [2047:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign d = TABLE[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational ROM; used by the key schedule.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] d
);
  // Entry for input x lives at bits [(255-x)*8 +: 8]; 255-x is just ~x.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign d = TABLE[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 decryptor: one round per clock, round keys expanded once
// per key load into an 11-entry store and reused for every following block.
module aes_inv_cipher_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done,
  output logic         kdone,
  output logic         busy
);

  fsm_t       state, next_state;
  logic [3:0] rnd;
  state_t     rk [0:NR];
  state_t     dat;

  logic key_start, blk_start, kexp_last, dec_last;

  // Key schedule: one 4-word group per cycle from the previous round key.
  state_t kprev, knext;
  word_t  krot, ksub, kt;

  assign kprev = rk[rnd - 4'd1];
  assign krot  = {kprev[23:0], kprev[31:24]};
  assign kt    = ksub ^ {rcon(rnd), 24'h000000};
  assign knext[127:96] = kprev[127:96] ^ kt;
  assign knext[95:64]  = kprev[95:64]  ^ knext[127:96];
  assign knext[63:32]  = kprev[63:32]  ^ knext[95:64];
  assign knext[31:0]   = kprev[31:0]   ^ knext[63:32];

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    aes_sbox u_sbox (.a(krot[8*g +: 8]), .d(ksub[8*g +: 8]));
  end

  // Round datapath: the final round simply skips InvMixColumns.
  state_t isr, isb, ark, mixed;

  assign isr = inv_shift_rows(dat);

  for (genvar g = 0; g < 16; g++) begin : g_isbox
    aes_inv_sbox u_inv_sbox (.a(isr[8*g +: 8]), .d(isb[8*g +: 8]));
  end

  assign ark = isb ^ rk[rnd];

  for (genvar g = 0; g < 4; g++) begin : g_imix
    assign mixed[32*g +: 32] = inv_mix_column(ark[32*g +: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    key_start  = 1'b0;
    blk_start  = 1'b0;
    kexp_last  = 1'b0;
    dec_last   = 1'b0;
    unique case (state)
      IDLE: begin
        if (kld) begin
          next_state = KEXP;
          key_start  = 1'b1;
        end else if (ld && kdone) begin
          next_state = DEC;
          blk_start  = 1'b1;
        end
      end
      KEXP: begin
        if (rnd == 4'(NR)) begin
          next_state = IDLE;
          kexp_last  = 1'b1;
        end
      end
      DEC: begin
        if (rnd == 4'd0) begin
          next_state = IDLE;
          dec_last   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      text_out <= '0;
      done     <= 1'b0;
      kdone    <= 1'b0;
      rnd      <= '0;
      dat      <= '0;
    end else begin
      done <= dec_last;
      if (key_start) begin
        rk[0] <= key;
        kdone <= 1'b0;
        rnd   <= 4'd1;
      end else if (blk_start) begin
        dat <= text_in ^ rk[NR];
        rnd <= 4'(NR - 1);
      end else if (state == KEXP) begin
        rk[rnd] <= knext;
        if (kexp_last) kdone <= 1'b1;
        else           rnd   <= rnd + 4'd1;
      end else if (state == DEC) begin
        if (dec_last) begin
          text_out <= ark;
        end else begin
          dat <= mixed;
          rnd <= rnd - 4'd1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Bench for aes_inv_cipher_top: known-answer table, protocol corner cases and a
// randomized round trip against an arithmetic AES-128 encryption model.
module tb_aes_inv_cipher_top;

  logic         clk, rst, kld, ld;
  logic [127:0] key, text_in, text_out;
  logic         done, kdone, busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  aes_inv_cipher_top dut (
    .clk(clk), .rst(rst), .kld(kld), .ld(ld), .key(key), .text_in(text_in),
    .text_out(text_out), .done(done), .kdone(kdone), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (from the algorithm's definition) -------
  logic [7:0] sb [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        inv = inv ^ r;
      end
      sb[x] = inv ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rkv, res;
    rkv = round_key(k, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkv[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w + 4*c] = t[w + 4*((c + w) % 4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
          s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
        end
      rkv = round_key(k, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkv[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bench helpers --------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Ticks until kdone (sel=0) or done (sel=1) is seen, bounded by limit.
  task automatic wait_for(input bit sel, input int unsigned limit, output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(sel ? done : kdone) && n < limit);
  endtask

  task automatic load_key(input string name, input logic [127:0] k);
    int unsigned n;
    key = k; kld = 1'b1;
    tick();
    kld = 1'b0;
    chk({name, " busy_kexp"}, 128'(busy), 128'd1);
    wait_for(1'b0, 30, n);
    chk({name, " kdone_latency"}, 128'(n), 128'd10);
    chk({name, " busy_after_kexp"}, 128'(busy), 128'd0);
  endtask

  task automatic decrypt(input string name, input logic [127:0] ct, input logic [127:0] pt);
    int unsigned n;
    text_in = ct; ld = 1'b1;
    tick();
    ld = 1'b0;
    wait_for(1'b1, 30, n);
    chk({name, " done_latency"}, 128'(n), 128'd10);
    chk({name, " text_out"}, text_out, pt);
    tick();
    chk({name, " done_one_cycle"}, 128'(done), 128'd0);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [127:0] k, p1, p2, c1, c2, prev;
    int unsigned  n, dones, rt_ok;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[2] = '{128'h10a58869d74be5a374cf867cfb473859, 128'h6d251e6944b051e04eaa6fb4dbf78465,
                128'h00000000000000000000000000000000};
    vecs[3] = '{128'h00000000000000000000000000000000, 128'h3f5b8cc9ea855a0afa7347d23e8d664e,
                128'hffffffffffffffffffffffffffffffff};

    build_sbox();
    rst = 1'b1; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset text_out", text_out, '0);
    chk("reset done", 128'(done), 128'd0);
    chk("reset kdone", 128'(kdone), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);

    // ld before any key: dropped
    text_in = vecs[0].ct; ld = 1'b1;
    tick();
    ld = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      dones += int'(done) + int'(busy);
      tick();
    end
    chk("ld_without_key activity", 128'(dones), 128'd0);

    // Known-answer table, fresh key each time; kld must not disturb text_out
    prev = '0;
    for (int v = 0; v < 4; v++) begin
      load_key($sformatf("kat%0d", v), vecs[v].key);
      chk($sformatf("kat%0d text_out_kept", v), text_out, prev);
      if (v == 0) chk("kat0 rk10", dut.rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      decrypt($sformatf("kat%0d", v), vecs[v].ct, vecs[v].pt);
      prev = vecs[v].pt;
    end

    // Key reuse, second ld on the done cycle
    k = vecs[1].key; p1 = rand128(); p2 = rand128();
    c1 = enc(k, p1); c2 = enc(k, p2);
    load_key("b2b", k);
    text_in = c1; ld = 1'b1;
    tick();
    ld = 1'b0;
    wait_for(1'b1, 30, n);
    chk("b2b first latency", 128'(n), 128'd10);
    chk("b2b first text_out", text_out, p1);
    text_in = c2; ld = 1'b1;
    wait_for(1'b1, 30, n);
    ld = 1'b0;
    chk("b2b done spacing", 128'(n), 128'd11);
    chk("b2b second text_out", text_out, p2);

    // Strobes during DEC are dropped
    p1 = rand128(); c1 = enc(k, p1);
    text_in = c1; ld = 1'b1;
    tick();
    ld = 1'b0;
    n = 0;
    do begin
      if (n == 2) begin kld = 1'b1; ld = 1'b1; key = rand128(); text_in = rand128(); end
      tick();
      kld = 1'b0; ld = 1'b0;
      n++;
    end while (!done && n < 30);
    chk("busy_strobes latency", 128'(n), 128'd10);
    chk("busy_strobes text_out", text_out, p1);
    chk("busy_strobes kdone", 128'(kdone), 128'd1);
    tick();

    // kld and ld together in IDLE: only key expansion
    k = rand128(); p1 = rand128(); c1 = enc(k, p1);
    key = k; kld = 1'b1; text_in = c1; ld = 1'b1;
    tick();
    kld = 1'b0; ld = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      dones += int'(done);
      tick();
    end
    chk("kld_ld_same done_count", 128'(dones), 128'd0);
    chk("kld_ld_same kdone", 128'(kdone), 128'd1);
    decrypt("kld_ld_same newkey", c1, p1);

    // Reset in the middle of DEC
    text_in = c1; ld = 1'b1;
    tick();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst text_out", text_out, '0);
    chk("midrst done", 128'(done), 128'd0);
    chk("midrst kdone", 128'(kdone), 128'd0);
    chk("midrst busy", 128'(busy), 128'd0);
    text_in = c1; ld = 1'b1;
    tick();
    ld = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      dones += int'(done) + int'(busy);
      tick();
    end
    chk("midrst ld_ignored", 128'(dones), 128'd0);

    // Randomized round trip through the encryption model
    rt_ok = 0;
    for (int t = 0; t < 100; t++) begin
      int unsigned bad0;
      bad0 = n_bad;
      k = rand128(); p1 = rand128();
      load_key($sformatf("rt%0d", t), k);
      decrypt($sformatf("rt%0d", t), enc(k, p1), p1);
      if (n_bad == bad0) rt_ok++;
    end
    $display("round-trip scoreboard %0d/100", rt_ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
